serial_to_parallel_rx: RTL and testbench

- Receive side of the board-level serial link: consumes the one-bit-per-button-press stream produced by the upstream parallel-to-serial stage and reassembles it into a parallel word.
- A strobe input (raw button, active-high after inversion at top level) is synchronised, debounced and edge-detected.
- Each accepted press samples the serial data line LSB-first.
- A completed word is presented with a one-cycle valid pulse. The current bit position is shown on a seven-segment digit.

---
 rtl/serial_to_parallel_rx.sv | 134 +++++++++++++
 tb/tb_serial_to_parallel_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: debounced strobe captures sdi LSB-first.
// Ports: clk, rst (sync, active-high), strobe_raw, sdi in;
//        data_o, data_valid, bit_count, word_count, hex_o out.
module serial_to_parallel_rx #(
    parameter  int WIDTH           = 8,
    parameter  int DEBOUNCE_CYCLES = 1250000,
    localparam int BC_W            = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe_raw,
    input  logic             sdi,
    output logic [WIDTH-1:0] data_o,
    output logic             data_valid,
    output logic [BC_W-1:0]  bit_count,
    output logic [7:0]       word_count,
    output logic [6:0]       hex_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

    logic             strobe_s1_q, strobe_s_q;
    logic             sdi_s1_q, sdi_s_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             db_lvl_q, db_lvl_d;
    logic             db_dly_q;
    logic             cap;
    // Top bit of a word never lands here; it goes straight into data_o.
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [7:0]       word_q, word_d;
    logic [6:0]       hex_q, hex_d;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Debounce: level must differ for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        db_cnt_d = db_cnt_q;
        db_lvl_d = db_lvl_q;
        if (strobe_s_q == db_lvl_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_lvl_d = strobe_s_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    assign cap = db_lvl_q & ~db_dly_q;

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        word_d    = word_q;
        if (cap) begin
            if (bit_cnt_q == BC_W'(WIDTH - 1)) begin
                data_d    = {sdi_s_q, shreg_q};
                valid_d   = 1'b1;
                word_d    = word_q + 8'd1;
                bit_cnt_d = '0;
                shreg_d   = '0;
            end else begin
                shreg_d[bit_cnt_q] = sdi_s_q;
                bit_cnt_d          = bit_cnt_q + BC_W'(1);
            end
        end
        hex_d = seg7(4'(bit_cnt_q));
    end

    // db and its delay reset high so a button held through reset
    // must be released and pressed again before it captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_s1_q <= 1'b0;
            strobe_s_q  <= 1'b0;
            sdi_s1_q    <= 1'b0;
            sdi_s_q     <= 1'b0;
            db_cnt_q    <= '0;
            db_lvl_q    <= 1'b1;
            db_dly_q    <= 1'b1;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            word_q      <= '0;
            hex_q       <= 7'b1000000;
        end else begin
            strobe_s1_q <= strobe_raw;
            strobe_s_q  <= strobe_s1_q;
            sdi_s1_q    <= sdi;
            sdi_s_q     <= sdi_s1_q;
            db_cnt_q    <= db_cnt_d;
            db_lvl_q    <= db_lvl_d;
            db_dly_q    <= db_lvl_q;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            word_q      <= word_d;
            hex_q       <= hex_d;
        end
    end

    assign data_o     = data_q;
    assign data_valid = valid_q;
    assign bit_count  = bit_cnt_q;
    assign word_count = word_q;
    assign hex_o      = hex_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench for serial_to_parallel_rx (WIDTH=8, DEBOUNCE_CYCLES=4).
// Completed words are checked against a queue of expected values.
module tb_serial_to_parallel_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       strobe_raw = 1'b0;
    logic       sdi = 1'b0;
    logic [7:0] data_o;
    logic       data_valid;
    logic [2:0] bit_count;
    logic [7:0] word_count;
    logic [6:0] hex_o;

    int vectors = 0;
    int miscompares = 0;
    int valid_cnt = 0;
    logic [7:0] exp_q [$];

    logic [6:0] seg_tab [0:7] = '{7'b1000000, 7'b1111001, 7'b0100100,
        7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    serial_to_parallel_rx #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .strobe_raw (strobe_raw),
        .sdi        (sdi),
        .data_o     (data_o),
        .data_valid (data_valid),
        .bit_count  (bit_count),
        .word_count (word_count),
        .hex_o      (hex_o)
    );

    always #5 clk = ~clk;

    // Every valid pulse must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            logic [7:0] e;
            valid_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid data_o=%h expected no word", data_o);
            end else begin
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    miscompares++;
                    $display("FAIL word data_o=%h expected %h", data_o, e);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic press(input logic b);
        @(negedge clk);
        sdi = b;
        strobe_raw = 1'b1;
        repeat (9) @(negedge clk);
        strobe_raw = 1'b0;
        repeat (9) @(negedge clk);
    endtask

    task automatic chk_bc(input string nm, input int e);
        vectors++;
        if (bit_count !== 3'(e)) begin
            miscompares++;
            $display("FAIL %s bit_count=%0d expected %0d", nm, bit_count, e);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        strobe_raw = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (data_o !== 8'h00 || data_valid !== 1'b0 || word_count !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs data=%h valid=%b wc=%0d expected 00 0 0",
                     data_o, data_valid, word_count);
        end
        repeat (20) @(negedge clk);
        chk_bc("held_through_reset", 0);
        vectors++;
        if (hex_o !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_hex hex=%b expected 1000000", hex_o);
        end
        strobe_raw = 1'b0;
        repeat (9) @(negedge clk);
        press(1'b1);
        chk_bc("first_press", 1);
        vectors++;
        if (hex_o !== 7'b1111001) begin
            miscompares++;
            $display("FAIL first_press_hex hex=%b expected 1111001", hex_o);
        end
    endtask

    task automatic test_word();
        logic [7:0] bits;
        int v0;
        bits = 8'hA5;
        do_reset();
        v0 = valid_cnt;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            press(bits[i]);
            chk_bc("word_step", (i + 1) % 8);
            vectors++;
            if (hex_o !== seg_tab[(i + 1) % 8]) begin
                miscompares++;
                $display("FAIL word_hex step=%0d hex=%b expected %b",
                         i, hex_o, seg_tab[(i + 1) % 8]);
            end
        end
        vectors++;
        if (data_o !== 8'hA5 || word_count !== 8'd1) begin
            miscompares++;
            $display("FAIL word_A5 data=%h wc=%0d expected a5 1", data_o, word_count);
        end
        vectors++;
        if (valid_cnt - v0 != 1) begin
            miscompares++;
            $display("FAIL valid_pulse count=%0d expected 1", valid_cnt - v0);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        @(negedge clk);
        sdi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            strobe_raw = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        chk_bc("bounce_no_early_cap", 0);
        strobe_raw = 1'b1;
        repeat (12) @(negedge clk);
        chk_bc("bouncy_press", 1);
        for (int i = 0; i < 4; i++) begin
            strobe_raw = (i % 2 == 1);
            repeat (2) @(negedge clk);
        end
        strobe_raw = 1'b0;
        repeat (12) @(negedge clk);
        chk_bc("bouncy_release", 1);
    endtask

    task automatic test_midword_reset();
        do_reset();
        repeat (3) press(1'b1);
        chk_bc("partial_three", 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_bc("partial_discard", 0);
        repeat (10) @(negedge clk);
        exp_q.push_back(8'h00);
        repeat (8) press(1'b0);
        vectors++;
        if (data_o !== 8'h00 || word_count !== 8'd1) begin
            miscompares++;
            $display("FAIL no_stale data=%h wc=%0d expected 00 1", data_o, word_count);
        end
    endtask

    task automatic test_wrap();
        int v0;
        do_reset();
        v0 = valid_cnt;
        for (int w = 0; w < 256; w++) begin
            exp_q.push_back(8'hFF);
            repeat (8) press(1'b1);
            if (w == 254) begin
                vectors++;
                if (word_count !== 8'd255) begin
                    miscompares++;
                    $display("FAIL wc_255 wc=%0d expected 255", word_count);
                end
            end
        end
        vectors++;
        if (word_count !== 8'd0 || data_o !== 8'hFF) begin
            miscompares++;
            $display("FAIL wrap wc=%0d data=%h expected 0 ff", word_count, data_o);
        end
        vectors++;
        if (valid_cnt - v0 != 256) begin
            miscompares++;
            $display("FAIL wrap_pulses count=%0d expected 256", valid_cnt - v0);
        end
    endtask

    task automatic test_rst_cap();
        int v0;
        do_reset();
        v0 = valid_cnt;
        repeat (7) press(1'b1);
        chk_bc("before_collision", 7);
        @(negedge clk);
        sdi = 1'b1;
        strobe_raw = 1'b1;
        // Two sync stages, four debounce counts, then cap is high
        // for the seventh edge; rst is made to hit that edge.
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        strobe_raw = 1'b0;
        repeat (12) @(negedge clk);
        chk_bc("collision_bc", 0);
        vectors++;
        if (data_o !== 8'h00 || word_count !== 8'd0 || valid_cnt != v0) begin
            miscompares++;
            $display("FAIL collision data=%h wc=%0d pulses=%0d expected 00 0 0",
                     data_o, word_count, valid_cnt - v0);
        end
        press(1'b0);
        chk_bc("after_collision", 1);
    endtask

    initial begin
        test_reset();
        test_word();
        test_bounce();
        test_midword_reset();
        test_wrap();
        test_rst_cap();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_words outstanding=%0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
